// File: rtl/sd_spi_pkg.sv
// Shared constants, state encoding and command-byte lookup for the SPI-mode SD card host.
package sd_spi_pkg;

    localparam int unsigned IDX_W       = 16;
    localparam int unsigned CMD_LEN     = 6;
    localparam int unsigned PWRUP_BYTES = 10;
    localparam int unsigned R7_BYTES    = 4;
    localparam int unsigned BLK_BYTES   = 512;
    localparam int unsigned CRC_BYTES   = 2;

    localparam logic [7:0] CMD0_B   = 8'h40;
    localparam logic [7:0] CMD8_B   = 8'h48;
    localparam logic [7:0] CMD55_B  = 8'h77;
    localparam logic [7:0] ACMD41_B = 8'h69;
    localparam logic [7:0] CMD17_B  = 8'h51;
    localparam logic [7:0] CRC0_B   = 8'h95;
    localparam logic [7:0] CRC8_B   = 8'h87;
    localparam logic [7:0] CRC55_B  = 8'h65;
    localparam logic [7:0] CRC41_B  = 8'h77;
    localparam logic [7:0] TOKEN_B  = 8'hFE;
    localparam logic [7:0] R1_IDLE  = 8'h01;
    localparam logic [7:0] R1_READY = 8'h00;
    localparam logic [7:0] IDLE_B   = 8'hFF;

    typedef enum logic [3:0] {
        ERR_NONE   = 4'd0,
        ERR_CMD0   = 4'd1,
        ERR_CMD8   = 4'd2,
        ERR_ACMD41 = 4'd3,
        ERR_CMD17  = 4'd4,
        ERR_TOKEN  = 4'd5,
        ERR_NCR    = 4'd6
    } err_e;

    typedef enum logic [3:0] {
        ST_PWRUP, ST_CMD0, ST_CMD8, ST_R7, ST_CMD55, ST_ACMD41, ST_GAP,
        ST_READY, ST_CMD17, ST_TOKEN, ST_DATA, ST_CRC, ST_DESEL, ST_ERR
    } state_e;

    // Byte to shift out for byte slot idx of state st; poll and data slots send FFh.
    function automatic logic [7:0] cmd_tx(input state_e st, input logic [IDX_W-1:0] idx,
                                          input logic [31:0] addr);
        logic [7:0] b;
        b = IDLE_B;
        if (idx < IDX_W'(CMD_LEN)) begin
            case (st)
                ST_CMD0:   b = (idx[2:0] == 3'd0) ? CMD0_B : (idx[2:0] == 3'd5) ? CRC0_B : 8'h00;
                ST_CMD8: begin
                    case (idx[2:0])
                        3'd0:    b = CMD8_B;
                        3'd3:    b = 8'h01;
                        3'd4:    b = 8'hAA;
                        3'd5:    b = CRC8_B;
                        default: b = 8'h00;
                    endcase
                end
                ST_CMD55:  b = (idx[2:0] == 3'd0) ? CMD55_B : (idx[2:0] == 3'd5) ? CRC55_B : 8'h00;
                ST_ACMD41: begin
                    case (idx[2:0])
                        3'd0:    b = ACMD41_B;
                        3'd1:    b = 8'h40;
                        3'd5:    b = CRC41_B;
                        default: b = 8'h00;
                    endcase
                end
                ST_CMD17: begin
                    case (idx[2:0])
                        3'd0:    b = CMD17_B;
                        3'd1:    b = addr[31:24];
                        3'd2:    b = addr[23:16];
                        3'd3:    b = addr[15:8];
                        3'd4:    b = addr[7:0];
                        default: b = IDLE_B;
                    endcase
                end
                default:   b = IDLE_B;
            endcase
        end
        return b;
    endfunction

endpackage

// File: rtl/sd_spi_byte.sv
// Mode-0 SPI byte engine: clock divider and 8-bit shifter, one byte per start pulse.
module sd_spi_byte #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] tx_byte,
    output logic [7:0] rx_byte,
    output logic       done,
    output logic       bus_clk,
    output logic       bus_mosi,
    input  logic       bus_miso
);
    localparam int unsigned CW = $clog2(CLK_DIV);

    logic          active;
    logic [CW-1:0] cnt;
    logic [3:0]    ph;
    logic [7:0]    sh;

    // done leads the final falling edge by one clk so a chained start lands exactly on it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active   <= 1'b0;
            cnt      <= '0;
            ph       <= '0;
            sh       <= '0;
            rx_byte  <= '0;
            done     <= 1'b0;
            bus_clk  <= 1'b0;
            bus_mosi <= 1'b1;
        end else begin
            done <= 1'b0;
            if (start) begin
                active   <= 1'b1;
                cnt      <= '0;
                ph       <= '0;
                sh       <= tx_byte;
                bus_clk  <= 1'b0;
                bus_mosi <= tx_byte[7];
            end else if (active) begin
                if (ph == 4'd15 && cnt == CW'(CLK_DIV - 2)) begin
                    done <= 1'b1;
                end
                if (cnt == CW'(CLK_DIV - 1)) begin
                    cnt <= '0;
                    ph  <= ph + 4'd1;
                    if (!ph[0]) begin
                        bus_clk <= 1'b1;
                        rx_byte <= {rx_byte[6:0], bus_miso};
                    end else begin
                        bus_clk <= 1'b0;
                        if (ph == 4'd15) begin
                            active   <= 1'b0;
                            bus_mosi <= 1'b1;
                        end else begin
                            sh       <= {sh[6:0], 1'b0};
                            bus_mosi <= sh[6];
                        end
                    end
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/sd_spi_host.sv
// SPI-mode SD card host: power-up, CMD0/CMD8/ACMD41 init, then CMD17 block reads streamed as bytes.
module sd_spi_host
    import sd_spi_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned NCR_MAX    = 8,
    parameter int unsigned ACMD41_MAX = 1000,
    parameter int unsigned TOKEN_MAX  = 2048
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_req,
    input  logic [31:0] rd_addr,
    output logic        ready,
    output logic        busy,
    output logic [7:0]  dout,
    output logic        dout_valid,
    output logic        blk_done,
    output logic        err,
    output logic [3:0]  err_code,
    output logic        bus_clk,
    output logic        bus_cs,
    output logic        bus_mosi,
    input  logic        bus_miso
);
    state_e           state, state_n;
    logic [IDX_W-1:0] idx, idx_n, att, att_n;
    logic [31:0]      addr_q;
    logic             boot, start, done, polled, got, ncr_last;
    logic             cs_n, ready_n, busy_n, dv_n, blk_n;
    logic [7:0]       tx, rx;
    err_e             code_n;

    sd_spi_byte #(.CLK_DIV(CLK_DIV)) u_byte (
        .clk(clk), .rst(rst), .start(start), .tx_byte(tx), .rx_byte(rx), .done(done),
        .bus_clk(bus_clk), .bus_mosi(bus_mosi), .bus_miso(bus_miso)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_PWRUP;
        else     state <= state_n;
    end

    // All byte-level decisions are made on done, when the just-finished byte is in rx
    always_comb begin
        state_n  = state;
        idx_n    = idx;
        att_n    = att;
        code_n   = ERR_NONE;
        polled   = idx >= IDX_W'(CMD_LEN);
        got      = rx != IDLE_B;
        ncr_last = idx == IDX_W'(CMD_LEN + NCR_MAX - 1);
        case (state)
            ST_PWRUP: if (done) begin
                if (idx == IDX_W'(PWRUP_BYTES - 1)) begin
                    state_n = ST_CMD0;
                    idx_n   = '0;
                end else idx_n = idx + IDX_W'(1);
            end
            ST_CMD0, ST_CMD8, ST_CMD55, ST_ACMD41, ST_CMD17: if (done) begin
                if (!polled) begin
                    idx_n = idx + IDX_W'(1);
                end else if (!got) begin
                    if (ncr_last) begin
                        state_n = ST_ERR;
                        code_n  = ERR_NCR;
                    end else idx_n = idx + IDX_W'(1);
                end else begin
                    idx_n = '0;
                    if (state == ST_CMD0) begin
                        state_n = (rx == R1_IDLE) ? ST_CMD8 : ST_ERR;
                        code_n  = ERR_CMD0;
                    end else if (state == ST_CMD8) begin
                        state_n = (rx == R1_IDLE) ? ST_R7 : ST_ERR;
                        code_n  = ERR_CMD8;
                    end else if (state == ST_CMD55) begin
                        state_n = ST_ACMD41;
                    end else if (state == ST_ACMD41) begin
                        att_n  = att + IDX_W'(1);
                        code_n = ERR_ACMD41;
                        if (rx == R1_READY)                                 state_n = ST_READY;
                        else if (rx == R1_IDLE && att_n < IDX_W'(ACMD41_MAX)) state_n = ST_GAP;
                        else                                                state_n = ST_ERR;
                    end else begin
                        state_n = (rx == R1_READY) ? ST_TOKEN : ST_ERR;
                        code_n  = ERR_CMD17;
                    end
                end
            end
            ST_R7: if (done) begin
                if (idx == IDX_W'(R7_BYTES - 1)) begin
                    state_n = ST_CMD55;
                    idx_n   = '0;
                    att_n   = '0;
                end else idx_n = idx + IDX_W'(1);
            end
            ST_GAP: if (done) begin
                state_n = ST_CMD55;
                idx_n   = '0;
            end
            ST_READY: if (rd_req) begin
                state_n = ST_CMD17;
                idx_n   = '0;
            end
            ST_TOKEN: if (done) begin
                code_n = ERR_TOKEN;
                if (rx == TOKEN_B) begin
                    state_n = ST_DATA;
                    idx_n   = '0;
                end else if (got || idx == IDX_W'(TOKEN_MAX - 1)) begin
                    state_n = ST_ERR;
                end else idx_n = idx + IDX_W'(1);
            end
            ST_DATA: if (done) begin
                if (idx == IDX_W'(BLK_BYTES - 1)) begin
                    state_n = ST_CRC;
                    idx_n   = '0;
                end else idx_n = idx + IDX_W'(1);
            end
            ST_CRC: if (done) begin
                if (idx == IDX_W'(CRC_BYTES - 1)) begin
                    state_n = ST_DESEL;
                    idx_n   = '0;
                end else idx_n = idx + IDX_W'(1);
            end
            ST_DESEL: if (done) state_n = ST_READY;
            ST_ERR:   state_n = ST_ERR;
            default:  state_n = ST_ERR;
        endcase
    end

    // Output decode from the next state so registered outputs line up with the new byte
    always_comb begin
        start   = boot || ((done || state == ST_READY) && state_n != ST_READY && state_n != ST_ERR);
        tx      = cmd_tx(state_n, idx_n, addr_q);
        cs_n    = 1'b0;
        case (state_n)
            ST_PWRUP, ST_READY, ST_DESEL, ST_ERR: cs_n = 1'b1;
            default:                              cs_n = 1'b0;
        endcase
        ready_n = state_n == ST_READY;
        busy_n  = state_n != ST_READY && state_n != ST_ERR;
        dv_n    = state == ST_DATA && done;
        blk_n   = state == ST_DESEL && done;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx        <= '0;
            att        <= '0;
            addr_q     <= '0;
            boot       <= 1'b1;
            bus_cs     <= 1'b1;
            ready      <= 1'b0;
            busy       <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
            blk_done   <= 1'b0;
            err        <= 1'b0;
            err_code   <= '0;
        end else begin
            idx        <= idx_n;
            att        <= att_n;
            boot       <= 1'b0;
            bus_cs     <= cs_n;
            ready      <= ready_n;
            busy       <= busy_n;
            dout_valid <= dv_n;
            blk_done   <= blk_n;
            if (state == ST_READY && rd_req) addr_q <= rd_addr;
            if (dv_n) dout <= rx;
            if (state_n == ST_ERR && state != ST_ERR) begin
                err      <= 1'b1;
                err_code <= code_n;
            end
        end
    end

endmodule

// File: tb/tb_sd_spi_host.sv
// Bench for sd_spi_host: behavioural SD card model on the SPI wires plus a dout scoreboard.
module tb_sd_spi_host;
    localparam int M_NORMAL = 0, M_NO_R1 = 1, M_ACMD_FAIL = 2, M_R1_BAD = 3, M_NOTOKEN = 4;

    logic        clk, rst, rd_req;
    logic [31:0] rd_addr;
    logic        ready, busy, dout_valid, blk_done, err;
    logic [7:0]  dout;
    logic [3:0]  err_code;
    logic        bus_clk, bus_cs, bus_mosi, card_miso;

    int errors = 0, checks = 0;
    int mode, n_dv, n_blk;

    sd_spi_host #(.CLK_DIV(2), .NCR_MAX(8), .ACMD41_MAX(5), .TOKEN_MAX(16)) dut (
        .clk(clk), .rst(rst), .rd_req(rd_req), .rd_addr(rd_addr), .ready(ready), .busy(busy),
        .dout(dout), .dout_valid(dout_valid), .blk_done(blk_done), .err(err), .err_code(err_code),
        .bus_clk(bus_clk), .bus_cs(bus_cs), .bus_mosi(bus_mosi), .bus_miso(card_miso)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Card model state
    logic [7:0]  c_rx, c_txsh, nxt;
    logic [7:0]  c_cmd [6];
    logic [7:0]  out_q [$];
    logic [7:0]  exp_q [$];
    logic [47:0] cmd17_log;
    int          c_bits, cmd_cnt, post_bytes, n_acmd41, n_cmd17, pwr_clks;
    bit          seen_cmd;

    task automatic card_reset();
        c_rx = 8'hFF; c_txsh = 8'hFF; c_bits = 0; cmd_cnt = 0; post_bytes = 0;
        n_acmd41 = 0; n_cmd17 = 0; pwr_clks = 0; seen_cmd = 0; cmd17_log = '0;
        card_miso = 1'b1;
        out_q.delete();
    endtask

    task automatic card_respond();
        case (c_cmd[0])
            8'h40: if (mode != M_NO_R1) out_q.push_back(8'h01);
            8'h48: begin
                out_q.push_back(8'h01); out_q.push_back(8'h00); out_q.push_back(8'h00);
                out_q.push_back(8'h01); out_q.push_back(8'hAA);
            end
            8'h77: out_q.push_back(8'h01);
            8'h69: begin
                n_acmd41++;
                out_q.push_back((mode == M_ACMD_FAIL || n_acmd41 < 3) ? 8'h01 : 8'h00);
            end
            8'h51: begin
                n_cmd17++;
                cmd17_log = {c_cmd[0], c_cmd[1], c_cmd[2], c_cmd[3], c_cmd[4], c_cmd[5]};
                if (mode == M_R1_BAD) out_q.push_back(8'h05);
                else begin
                    out_q.push_back(8'h00);
                    if (mode != M_NOTOKEN) begin
                        out_q.push_back(8'hFF); out_q.push_back(8'hFF); out_q.push_back(8'hFE);
                        for (int i = 0; i < 512; i++) out_q.push_back(i[0] ? 8'hAA : 8'h55);
                        out_q.push_back(8'h12); out_q.push_back(8'h34);
                    end
                end
            end
            default: ;
        endcase
    endtask

    task automatic card_byte(input logic [7:0] b);
        if (cmd_cnt == 0) begin
            if (b[7:6] == 2'b01) begin
                c_cmd[0] = b;
                cmd_cnt = 1;
            end else post_bytes++;
        end else begin
            c_cmd[cmd_cnt] = b;
            cmd_cnt++;
            if (cmd_cnt == 6) begin
                cmd_cnt = 0;
                post_bytes = 0;
                card_respond();
            end
        end
    endtask

    always @(posedge bus_clk) begin
        if (!bus_cs) begin
            seen_cmd = 1;
            c_rx = {c_rx[6:0], bus_mosi};
            c_bits++;
            if (c_bits == 8) begin
                c_bits = 0;
                card_byte(c_rx);
            end
        end else if (!seen_cmd) pwr_clks++;
    end

    always @(negedge bus_clk) begin
        if (!bus_cs) begin
            if (c_bits == 0) begin
                nxt = (out_q.size() > 0) ? out_q.pop_front() : 8'hFF;
                card_miso = nxt[7];
                c_txsh = {nxt[6:0], 1'b0};
            end else begin
                card_miso = c_txsh[7];
                c_txsh = {c_txsh[6:0], 1'b0};
            end
        end
    end

    // Scoreboard monitor: every data strobe is matched against the expected queue
    always @(negedge clk) begin
        if (!rst && dout_valid) begin
            n_dv++;
            if (exp_q.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL dout_unexpected: got %0h with empty expected queue", dout);
            end else check("dout", 64'(dout), 64'(exp_q.pop_front()));
        end
        if (!rst && blk_done) n_blk++;
    end

    task automatic check_reset_outs(input string tag);
        check({tag, "_ctl"}, 64'({bus_clk, bus_cs, bus_mosi, ready, busy, dout_valid, blk_done, err}),
              64'(8'b0110_0000));
        check({tag, "_dout"}, 64'(dout), 64'h0);
        check({tag, "_code"}, 64'(err_code), 64'h0);
    endtask

    task automatic do_reset(input int m);
        rst = 1'b1;
        mode = m;
        card_reset();
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 20000 && !ready && !err; i++) @(negedge clk);
        check("ready", 64'(ready), 64'h1);
    endtask

    task automatic wait_err();
        for (int i = 0; i < 20000 && !err; i++) @(negedge clk);
        check("err", 64'(err), 64'h1);
    endtask

    task automatic pulse_req(input logic [31:0] a);
        rd_addr = a;
        rd_req = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
        rd_addr = 32'hFFFF_FFFF;
    endtask

    task automatic push_block();
        for (int i = 0; i < 512; i++) exp_q.push_back(i[0] ? 8'hAA : 8'h55);
    endtask

    initial begin
        rst = 1'b1; rd_req = 1'b0; rd_addr = '0; mode = M_NORMAL; n_dv = 0; n_blk = 0;
        card_reset();
        repeat (5) @(negedge clk);
        check_reset_outs("reset");
        rst = 1'b0;

        // rd_req during power-up must be ignored
        repeat (200) @(negedge clk);
        pulse_req(32'hDEAD_BEEF);
        wait_ready();
        check("init_err", 64'(err), 64'h0);
        check("pwrup_clocks", 64'(pwr_clks), 64'd80);
        check("acmd41_pairs", 64'(n_acmd41), 64'd3);
        check("early_req_ignored", 64'(n_cmd17), 64'd0);

        // Normal block read; rd_addr is scrambled right after acceptance
        n_dv = 0; n_blk = 0;
        push_block();
        pulse_req(32'h0000_1234);
        for (int i = 0; i < 40000 && n_blk == 0; i++) @(negedge clk);
        repeat (200) @(negedge clk);
        check("cmd17_bytes", 64'(cmd17_log), 64'h51_00_00_12_34_FF);
        check("dv_count", 64'(n_dv), 64'd512);
        check("exp_drained", 64'(exp_q.size()), 64'd0);
        check("blk_done_count", 64'(n_blk), 64'd1);
        check("ready_after_blk", 64'(ready), 64'h1);

        // Reset in the middle of the data phase
        n_dv = 0;
        push_block();
        pulse_req(32'h0000_0010);
        for (int i = 0; i < 40000 && n_dv < 100; i++) @(negedge clk);
        #2 rst = 1'b1;
        #1 check_reset_outs("async_rst");
        check("dv_before_rst", 64'(n_dv), 64'd100);
        do_reset(M_NORMAL);
        wait_ready();
        check("pwrup_clocks_again", 64'(pwr_clks), 64'd80);
        check("reinit_acmd41", 64'(n_acmd41), 64'd3);

        // CMD17 rejected by the card
        mode = M_R1_BAD;
        pulse_req(32'h0000_0001);
        wait_err();
        check("cmd17_code", 64'(err_code), 64'd4);
        check("cmd17_cs", 64'(bus_cs), 64'h1);

        // No response at all to CMD0
        do_reset(M_NO_R1);
        wait_err();
        check("ncr_code", 64'(err_code), 64'd6);
        check("ncr_polls", 64'(post_bytes), 64'd8);
        check("ncr_cs", 64'(bus_cs), 64'h1);
        repeat (100) @(negedge clk);
        check("err_sticky", 64'({err, bus_clk, ready}), 64'(3'b100));

        // ACMD41 never leaves idle
        do_reset(M_ACMD_FAIL);
        wait_err();
        check("acmd41_code", 64'(err_code), 64'd3);
        check("acmd41_attempts", 64'(n_acmd41), 64'd5);

        // Start token never arrives
        do_reset(M_NOTOKEN);
        wait_ready();
        n_dv = 0;
        pulse_req(32'h0000_0002);
        wait_err();
        check("token_code", 64'(err_code), 64'd5);
        check("token_polls", 64'(post_bytes), 64'd17);
        check("token_no_dv", 64'(n_dv), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
